store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_pkg.sv | 14 +
 rtl/sb_fwd_merge.sv | 29 ++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and sizing for the store buffer.
package store_pkg;

    localparam int SB_BE_W  = 4;
    localparam int SB_DEPTH = 4;

    // One buffered store: word address (byte offset dropped), data, byte lanes.
    typedef struct packed {
        logic [29:0]        word_addr;
        logic [31:0]        data;
        logic [SB_BE_W-1:0] be;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding merge. Entries arrive ordered oldest (index 0)
// to youngest. For each byte lane the youngest valid matching entry wins.
module sb_fwd_merge
    import store_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic [DEPTH-1:0]      ent_vld,
    input  sb_entry_t [DEPTH-1:0] ent,
    input  logic [29:0]           ld_word,
    output logic [SB_BE_W-1:0]    fwd_be,
    output logic [31:0]           fwd_data
);

    for (genvar l = 0; l < SB_BE_W; l++) begin : g_lane
        // Scan oldest to youngest so later (younger) hits overwrite older ones.
        always_comb begin
            fwd_be[l]           = 1'b0;
            fwd_data[8*l +: 8]  = 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && ent[i].be[l] && (ent[i].word_addr == ld_word)) begin
                    fwd_be[l]          = 1'b1;
                    fwd_data[8*l +: 8] = ent[i].data[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the store datapath and data memory.
// Optional store-to-load forwarding is compiled in when STORE_BUFFER_FWD_EN
// is defined; otherwise the forwarding ports and logic do not exist.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_wdata,
    input  logic [3:0]               st_be,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
`ifdef STORE_BUFFER_FWD_EN
    ,
    input  logic [31:0]              ld_addr,
    output logic [3:0]               fwd_be,
    output logic [31:0]              fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    sb_entry_t entries_q [DEPTH];
    sb_entry_t entry_d;
    sb_entry_t head;

    logic push;
    logic pop;

    // Readiness depends only on registered occupancy, never on mem_gnt.
    assign st_ready  = (count_q != CNT_W'(DEPTH));
    assign mem_req   = (count_q != '0);
    assign sb_empty  = (count_q == '0);
    assign sb_count  = count_q;

    // A zero-lane store is handshaken but never occupies an entry.
    assign push      = st_valid && st_ready && (st_be != 4'b0000);
    assign pop       = mem_req && mem_gnt;

    assign head      = entries_q[rd_ptr_q];
    assign mem_addr  = {head.word_addr, 2'b00};
    assign mem_wdata = head.data;
    assign mem_be    = head.be;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        entry_d  = '{word_addr: st_addr[31:2], data: st_wdata, be: st_be};
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset drops any queued stores on the floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; validity comes from the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) entries_q[wr_ptr_q] <= entry_d;
    end

`ifdef STORE_BUFFER_FWD_EN
    sb_entry_t [DEPTH-1:0] ord_ent;
    logic      [DEPTH-1:0] ord_vld;

    // Rotate storage so index 0 is the head (oldest) and validity is by age.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_ent[i] = entries_q[rd_ptr_q + PTR_W'(i)];
            ord_vld[i] = (CNT_W'(i) < count_q);
        end
    end

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
        .ent_vld  (ord_vld),
        .ent      (ord_ent),
        .ld_word  (ld_addr[31:2]),
        .fwd_be   (fwd_be),
        .fwd_data (fwd_data)
    );
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of expected drains.
module tb_store_buffer;
    import store_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        sb_empty;
    logic [2:0]  sb_count;
`ifdef STORE_BUFFER_FWD_EN
    logic [31:0] ld_addr;
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    sb_entry_t exp_q[$];
    sb_entry_t e;
    bit mpush, mpop;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .sb_empty  (sb_empty),
        .sb_count  (sb_count)
`ifdef STORE_BUFFER_FWD_EN
        ,
        .ld_addr   (ld_addr),
        .fwd_be    (fwd_be),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("sb_count", 32'(sb_count), 32'(mcount));
        chk("st_ready", 32'(st_ready), 32'(mcount != DEPTH));
        chk("mem_req",  32'(mem_req),  32'(mcount != 0));
        chk("sb_empty", 32'(sb_empty), 32'(mcount == 0));
    endtask

    // Advance one cycle and compare status against the model.
    task automatic cyc();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = v;
        st_addr  = a;
        st_wdata = d;
        st_be    = b;
    endtask

    // Model: decides pushes/pops from stimulus and its own occupancy, and
    // checks head contents against the scoreboard whenever a pop happens.
    always @(negedge clk) begin
        if (rst_n) begin
            mpop  = (mcount != 0) && mem_gnt;
            mpush = st_valid && (mcount != DEPTH) && (st_be != 4'b0000);
            if (mpop) begin
                if (exp_q.size() == 0) begin
                    chk("drain_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_addr",  mem_addr,      {e.word_addr, 2'b00});
                    chk("drain_wdata", mem_wdata,     e.data);
                    chk("drain_be",    32'(mem_be),   32'(e.be));
                end
            end
            if (mpush) exp_q.push_back('{word_addr: st_addr[31:2], data: st_wdata, be: st_be});
            mcount = mcount + int'(mpush) - int'(mpop);
        end
    end

    initial begin
        rst_n   = 1'b0;
        mem_gnt = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
`ifdef STORE_BUFFER_FWD_EN
        ld_addr = 32'h0;
`endif
        #1;
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_sb_count", 32'(sb_count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single byte-lane store, held at head without a grant.
        drive(1'b1, 32'h0000_1001, 32'h0000_DD00, 4'b0010);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            chk("single_req",   32'(mem_req),  32'd1);
            chk("single_addr",  mem_addr,      32'h0000_1000);
            chk("single_wdata", mem_wdata,     32'h0000_DD00);
            chk("single_be",    32'(mem_be),   32'b0010);
            chk("single_count", 32'(sb_count), 32'd1);
            cyc();
        end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        chk("single_drained", 32'(sb_count), 32'd0);

        // Zero-lane store: handshaken, never buffered.
        drive(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 4'b0000);
        #1;
        chk("be0_ready", 32'(st_ready), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("be0_count", 32'(sb_count), 32'd0);
        chk("be0_req",   32'(mem_req),  32'd0);

        // Fill to full, refuse a fifth, then one grant frees a slot next cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111);
            cyc();
        end
        drive(1'b1, 32'h0000_3010, 32'hBAD0_0005, 4'b1111);
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_count", 32'(sb_count), 32'd4);
        cyc();
        chk("full_hold_count", 32'(sb_count), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        mem_gnt = 1'b1;
        #1;
        chk("full_pop_ready_same", 32'(st_ready), 32'd0);
        cyc();
        chk("full_pop_count", 32'(sb_count), 32'd3);
        chk("full_pop_ready", 32'(st_ready), 32'd1);
        repeat (3) cyc();
        mem_gnt = 1'b0;

        // Streaming with a grant every cycle, wrapping the pointers.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0000_4000 + 32'(i * 4), 32'h1234_0000 + 32'(i * 17), 4'(i % 15 + 1));
            mem_gnt = 1'b1;
            cyc();
            chk("stream_count", 32'(sb_count), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        mem_gnt = 1'b0;
        chk("stream_empty", 32'(sb_empty), 32'd1);

`ifdef STORE_BUFFER_FWD_EN
        // Forwarding merges lanes from the youngest matching entries.
        drive(1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'b1111);
        cyc();
        drive(1'b1, 32'h0000_2002, 32'h1122_0000, 4'b1100);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        ld_addr = 32'h0000_2000;
        #1;
        chk("fwd_be",   32'(fwd_be), 32'b1111);
        chk("fwd_data", fwd_data,    32'h1122_CCDD);
        mem_gnt = 1'b1;
        #1;
        chk("fwd_pop_be",   32'(fwd_be), 32'b1111);
        chk("fwd_pop_data", fwd_data,    32'h1122_CCDD);
        ld_addr = 32'h0000_2004;
        #1;
        chk("fwd_miss_be",   32'(fwd_be), 32'b0000);
        chk("fwd_miss_data", fwd_data,    32'h0);
        cyc();
        cyc();
        mem_gnt = 1'b0;
`endif

        // Reset mid-drain discards everything, without waiting for an edge.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_6000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111);
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("pre_rst_count", 32'(sb_count), 32'd3);
        #2;
        rst_n = 1'b0;
        mcount = 0;
        exp_q.delete();
        drive(1'b1, 32'h0000_7000, 32'h7777_7777, 4'b1111);
        mem_gnt = 1'b1;
        #1;
        chk("arst_mem_req",  32'(mem_req),  32'd0);
        chk("arst_sb_empty", 32'(sb_empty), 32'd1);
        chk("arst_sb_count", 32'(sb_count), 32'd0);
        chk("arst_st_ready", 32'(st_ready), 32'd1);
        cyc();
        cyc();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("post_rst_req", 32'(mem_req), 32'd0);

        // Buffer still works after reset.
        drive(1'b1, 32'h0000_8008, 32'h5566_7788, 4'b0101);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        mem_gnt = 1'b0;
        chk("final_empty", 32'(sb_empty), 32'd1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
